// File: rtl/md_pkg.sv
// Shared opcode, state and constant definitions for the multiply/divide sequencer.
// The decoder/control unit imports this package so that both sides use the same op encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Wide enough for any supported XLEN; users take the low XLEN bits.
  localparam int unsigned MD_XLEN_MAX = 64;
  localparam logic [MD_XLEN_MAX-1:0] MD_DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply (mode=0) or
// restoring shift-subtract divide (mode=1). Purely combinational.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN:0]   acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    addend  = acc_lo[0] ? opnd : '0;
    sum     = acc_hi + {1'b0, addend};
    shifted = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (!mode) begin
      // Multiplier bits leave acc_lo from the bottom as product bits enter from the top.
      nxt_hi = {1'b0, sum[XLEN:1]};
      nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      nxt_hi = diff;
      nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      nxt_hi = shifted;
      nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO; raises busy while an
// operation is in flight so the hazard unit can stall the pipeline.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_t       state, state_nxt;
  md_op_t          op_e;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;
  logic            sgn, sa, sb, is_div, div0;

  logic            go, go_md, ld_sgn, ld_sa, ld_sb, ld_div0;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0]   nxt_hi;
  logic [XLEN-1:0] nxt_lo;
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0] quot, rem;
  logic            neg_res;

  // Request decode and operand magnitudes for the load edge.
  always_comb begin
    op_e    = md_op_t'(op);
    go      = (state == IDLE) && start && !abort;
    go_md   = go && !op[2];
    ld_sgn  = !op[0];
    ld_sa   = ld_sgn && a[XLEN-1];
    ld_sb   = ld_sgn && b[XLEN-1];
    ld_div0 = op[1] && (b == '0);
    ma      = ld_sa ? -a : a;
    mb      = ld_sb ? -b : b;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode   (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // Sign fixup of the finished magnitudes.
  always_comb begin
    neg_res  = sgn && (sa ^ sb);
    prod_mag = {acc_hi[XLEN-1:0], acc_lo};
    prod     = neg_res ? -prod_mag : prod_mag;
    quot     = neg_res ? -acc_lo : acc_lo;
    rem      = (sgn && sa) ? -acc_hi[XLEN-1:0] : acc_hi[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go_md) state_nxt = ld_div0 ? FIX : CALC;
      CALC: begin
        if (abort)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIX) && !abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      sgn    <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          case (op_e)
            MD_MTHI: hi <= a;
            MD_MTLO: lo <= a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              sgn    <= ld_sgn;
              sa     <= ld_sa;
              sb     <= ld_sb;
              is_div <= op[1];
              div0   <= ld_div0;
              cnt    <= '0;
              acc_hi <= '0;
              // Divide-by-zero keeps the raw dividend so FIX can return it in HI.
              acc_lo <= ld_div0 ? a : (op[1] ? ma : mb);
              opnd   <= op[1] ? mb : ma;
            end
            default: ;
          endcase
        end
        CALC: if (!abort) begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        FIX: if (!abort) begin
          if (div0) begin
            hi <= acc_lo;
            lo <= MD_DIV0_LO[XLEN-1:0];
          end else if (is_div) begin
            hi <= rem;
            lo <= quot;
          end else begin
            hi <= prod[2*XLEN-1:XLEN];
            lo <= prod[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl with hand-computed HI/LO, latency and control expectations.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait (bounded) for busy to drop, counting busy cycles and done pulses.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int cyc, output int dn);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; dn = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) dn++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc, dn;

    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, cyc, dn);
    check("mult_cycles", cyc, 33);
    check("mult_done", dn, 1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, dn);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, dn);
    check("mult_m1_hi", hi, 32'h0);
    check("mult_m1_lo", lo, 32'h1);

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, dn);
    check("div_cycles", cyc, 33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc, dn);
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'h1);

    run_op(3'd3, 32'd5, 32'd0, cyc, dn);
    check("div0_cycles", cyc, 1);
    check("div0_done", dn, 1);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'hFFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, dn);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);

    // Control ops from a known HI/LO.
    run_op(3'd4, 32'h11111111, 32'd0, cyc, dn);
    run_op(3'd5, 32'h11111111, 32'd0, cyc, dn);
    check("mtlo_lo", lo, 32'h11111111);
    run_op(3'd4, 32'h12345678, 32'd0, cyc, dn);
    check("mthi_busy_cycles", cyc, 0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo_kept", lo, 32'h11111111);

    run_op(3'd6, 32'hAAAAAAAA, 32'd3, cyc, dn);
    check("op6_cycles", cyc, 0);
    check("op6_hi", hi, 32'h12345678);
    check("op6_lo", lo, 32'h11111111);

    // Abort in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_after", busy, 0);
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_hi", hi, 32'h12345678);
    check("abort_lo", lo, 32'h11111111);

    // New request while busy is not accepted.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_ign_lo", lo, 32'd14);
    check("busy_ign_hi", hi, 32'd2);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_stays_idle", busy, 0);
    check("arst_no_write", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
